// File: rtl/dlx_alu_pkg.sv
// dlx_alu_pkg: opcodes, FP constants and shared normalize/round helpers for the DLX ALU.
package dlx_alu_pkg;
  typedef enum logic [4:0] {
    OP_AND    = 5'b00000,
    OP_OR     = 5'b00001,
    OP_ADD    = 5'b00010,
    OP_SUB    = 5'b00011,
    OP_XOR    = 5'b00100,
    OP_SLL    = 5'b00101,
    OP_SRL    = 5'b00110,
    OP_SLTU   = 5'b00111,
    OP_SLT    = 5'b01000,
    OP_SGE    = 5'b01001,
    OP_ADDF   = 5'b01111,
    OP_CVTITF = 5'b11110
  } alu_op_e;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int BIAS = 127;

  function automatic logic [5:0] lzc32(input logic [31:0] v);
    lzc32 = 6'd32;
    for (int i = 0; i < 32; i++) if (v[i]) lzc32 = 6'(31 - i);
  endfunction

  // n holds hidden bit at [26], fraction [25:3], guard [2], round [1], sticky [0];
  // e is the biased exponent of n. Returns {overflow, packed float}.
  function automatic logic [32:0] round_pack(input logic s, input logic signed [9:0] e,
                                             input logic [26:0] n);
    logic inc;
    logic [24:0] m;
    logic signed [9:0] ef;
    inc = n[2] & (n[1] | n[0] | n[3]);
    m = {1'b0, n[26:3]} + {24'd0, inc};
    ef = m[24] ? e + 10'sd1 : e;
    if (ef > 10'sd254) round_pack = {1'b1, s, 8'hFF, 23'd0};
    else if (ef < 10'sd1) round_pack = 33'd0;
    else round_pack = {1'b0, s, ef[7:0], m[24] ? m[23:1] : m[22:0]};
  endfunction
endpackage

// File: rtl/dlx_alu_fp_add32.sv
// dlx_fp_add32: combinational single-precision adder, flush-to-zero, round-to-nearest-even.
module dlx_fp_add32
  import dlx_alu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y,
  output logic        o_ovf
);
  logic        w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_special, w_nan, w_swap;
  logic [31:0] w_af, w_bf, w_x, w_y;
  logic [26:0] w_mx, w_my, w_mya, w_n, w_shl;
  logic [7:0]  w_d;
  logic [53:0] w_wide;
  logic [27:0] w_sum;
  logic [5:0]  w_lz;
  logic signed [9:0] w_e;
  logic [32:0] w_rp;

  assign w_a_inf = (&i_a[30:23]) & ~(|i_a[22:0]);
  assign w_b_inf = (&i_b[30:23]) & ~(|i_b[22:0]);
  assign w_a_nan = (&i_a[30:23]) & (|i_a[22:0]);
  assign w_b_nan = (&i_b[30:23]) & (|i_b[22:0]);
  assign w_nan = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (i_a[31] ^ i_b[31]));
  assign w_special = w_nan | w_a_inf | w_b_inf;

  assign w_af = (i_a[30:23] == 8'd0) ? {i_a[31], 31'd0} : i_a;
  assign w_bf = (i_b[30:23] == 8'd0) ? {i_b[31], 31'd0} : i_b;
  assign w_swap = w_bf[30:0] > w_af[30:0];
  assign w_x = w_swap ? w_bf : w_af;
  assign w_y = w_swap ? w_af : w_bf;

  // Three guard bits below the fraction; shifted-out bits collapse into the sticky lsb.
  assign w_mx = {|w_x[30:23], w_x[22:0], 3'b000};
  assign w_my = {|w_y[30:23], w_y[22:0], 3'b000};
  assign w_d = w_x[30:23] - w_y[30:23];
  assign w_wide = {w_my, 27'd0} >> ((w_d > 8'd27) ? 8'd27 : w_d);
  assign w_mya = w_wide[53:27] | {26'd0, |w_wide[26:0]};
  assign w_sum = (w_x[31] == w_y[31]) ? {1'b0, w_mx} + {1'b0, w_mya}
                                      : {1'b0, w_mx} - {1'b0, w_mya};

  assign w_lz = lzc32({w_sum, 4'd0});
  assign w_shl = 27'(w_sum << (w_lz - 6'd1));
  assign w_n = (w_lz == 6'd0) ? {w_sum[27:2], |w_sum[1:0]} : w_shl;
  assign w_e = $signed({2'b00, w_x[30:23]}) + 10'sd1 - $signed({4'b0000, w_lz});
  assign w_rp = round_pack(w_x[31], w_e, w_n);

  assign o_y = w_nan ? QNAN : w_a_inf ? i_a : w_b_inf ? i_b :
               (w_sum == 28'd0) ? 32'd0 : w_rp[31:0];
  assign o_ovf = ~w_special & (w_sum != 28'd0) & w_rp[32];
endmodule

// File: rtl/dlx_alu.sv
// dlx_alu: DLX execute-stage ALU with integer, FP add and int-to-float ops, registered outputs.
module dlx_alu
  import dlx_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  Op,
  output logic [31:0] Result,
  output logic        Carryout,
  output logic        Overflow,
  output logic        Zero,
  output logic        Set
);
  logic [32:0] w_add, w_sub;
  logic        w_add_v, w_sub_v, w_set, w_fp_v, w_c, w_v;
  logic [31:0] w_fp, w_mag, w_norm, w_cvt, w_res;
  logic [5:0]  w_cvt_lz;
  logic [31:0] r_result;
  logic        r_carry, r_ovf, r_zero, r_set;

  assign w_add = {1'b0, A} + {1'b0, B};
  assign w_sub = {1'b0, A} + {1'b0, ~B} + 33'd1;
  assign w_add_v = (A[31] == B[31]) & (w_add[31] ^ A[31]);
  assign w_sub_v = (A[31] != B[31]) & (w_sub[31] ^ A[31]);
  assign w_set = w_sub[31] ^ w_sub_v;

  // The most negative int negates to itself, which is its correct unsigned magnitude.
  assign w_mag = A[31] ? -A : A;
  assign w_cvt_lz = lzc32(w_mag);
  assign w_norm = w_mag << w_cvt_lz;
  assign w_cvt = (A == 32'd0) ? 32'd0 :
                 32'(round_pack(A[31], 10'(BIAS + 31) - {4'd0, w_cvt_lz},
                                {w_norm[31:6], |w_norm[5:0]}));

  dlx_fp_add32 u_fp_add (
    .i_a  (A),
    .i_b  (B),
    .o_y  (w_fp),
    .o_ovf(w_fp_v)
  );

  always_comb begin
    w_res = 32'd0;
    w_c = 1'b0;
    w_v = 1'b0;
    case (Op)
      OP_AND:    w_res = A & B;
      OP_OR:     w_res = A | B;
      OP_XOR:    w_res = A ^ B;
      OP_ADD:    {w_c, w_res, w_v} = {w_add, w_add_v};
      OP_SUB:    {w_c, w_res, w_v} = {w_sub, w_sub_v};
      OP_SLL:    w_res = A << B[4:0];
      OP_SRL:    w_res = A >> B[4:0];
      OP_SLTU:   w_res = {31'd0, ~w_sub[32]};
      OP_SLT:    w_res = {31'd0, w_set};
      OP_SGE:    w_res = {31'd0, ~w_set};
      OP_ADDF:   {w_res, w_v} = {w_fp, w_fp_v};
      OP_CVTITF: w_res = w_cvt;
      default:   w_res = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= 32'd0;
      r_carry <= 1'b0;
      r_ovf <= 1'b0;
      r_zero <= 1'b0;
      r_set <= 1'b0;
    end else begin
      r_result <= w_res;
      r_carry <= w_c;
      r_ovf <= w_v;
      r_zero <= (w_res == 32'd0);
      r_set <= w_set;
    end
  end

  assign Result = r_result;
  assign Carryout = r_carry;
  assign Overflow = r_ovf;
  assign Zero = r_zero;
  assign Set = r_set;
endmodule

// File: tb/tb_dlx_alu.sv
// tb_dlx_alu: scoreboard bench for dlx_alu; expected {Result,C,V,Z,S} queued at issue.
module tb_dlx_alu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic [4:0]  Op = 5'd0;
  logic [31:0] Result;
  logic        Carryout, Overflow, Zero, Set;

  typedef struct {
    string       tag;
    logic [35:0] exp;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;

  dlx_alu dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .Op(Op),
    .Result(Result), .Carryout(Carryout), .Overflow(Overflow), .Zero(Zero), .Set(Set)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got R=%h C%b V%b Z%b S%b, want R=%h C%b V%b Z%b S%b", tag,
                  got[35:4], got[3], got[2], got[1], got[0],
                  exp[35:4], exp[3], exp[2], exp[1], exp[0]);
  endtask

  function automatic logic [35:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic c, v;
    logic [63:0] u;
    longint t;
    logic [4:0] sh;
    r = 32'd0; c = 1'b0; v = 1'b0; sh = b[4:0];
    case (op)
      5'b00000: r = a & b;
      5'b00001: r = a | b;
      5'b00100: r = a ^ b;
      5'b00010: begin
        u = {32'd0, a} + {32'd0, b};
        r = u[31:0]; c = u[32];
        t = longint'($signed(a)) + longint'($signed(b));
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      5'b00011: begin
        r = a - b; c = (a >= b);
        t = longint'($signed(a)) - longint'($signed(b));
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      5'b00101: r = a << sh;
      5'b00110: r = a >> sh;
      5'b00111: r = {31'd0, a < b};
      5'b01000: r = {31'd0, $signed(a) < $signed(b)};
      5'b01001: r = {31'd0, $signed(a) >= $signed(b)};
      default:  r = 32'd0;
    endcase
    model = {r, c, v, r == 32'd0, $signed(a) < $signed(b)};
  endfunction

  task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] fr = 32'd0,
                       input logic fv = 1'b0);
    exp_t e;
    @(negedge clk);
    Op = op; A = a; B = b;
    e.tag = tag;
    e.exp = (op == 5'b01111 || op == 5'b11110)
            ? {fr, 1'b0, fv, fr == 32'd0, $signed(a) < $signed(b)} : model(op, a, b);
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(e.tag, {Result, Carryout, Overflow, Zero, Set}, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [4:0] iops [12];
    iops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
             5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b11111};
    #1 chk("reset_state", {Result, Carryout, Overflow, Zero, Set}, 36'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    issue("add_ovf", 5'b00010, 32'd100, 32'd2147483645);
    issue("add_m1p1", 5'b00010, 32'hFFFFFFFF, 32'd1);
    issue("add_negs", 5'b00010, -32'd45, -32'd20);
    issue("sub_5_4", 5'b00011, 32'd5, 32'd4);
    issue("sub_neg", 5'b00011, -32'd5, -32'd70);
    issue("slt", 5'b01000, -32'd15, -32'd7);
    issue("sll", 5'b00101, 32'd1023, 32'd2);
    issue("srl", 5'b00110, 32'd1023, 32'd2);
    issue("sll_0", 5'b00101, 32'hDEADBEEF, 32'hFFFFFFE0);
    issue("srl_31", 5'b00110, 32'h80000000, 32'd31);
    issue("sltu", 5'b00111, 32'd1024, 32'd2133);
    issue("sge", 5'b01001, 32'd3024, 32'd2133);
    issue("undef", 5'b10101, 32'd9, 32'd3);

    issue("addf_15_240", 5'b01111, 32'h41700000, 32'h43700000, 32'h437F0000);
    issue("addf_1_1", 5'b01111, 32'h3F800000, 32'h3F800000, 32'h40000000);
    issue("addf_cancel", 5'b01111, 32'h3F800000, 32'hBF800000, 32'h0);
    issue("addf_nan", 5'b01111, 32'h7F800001, 32'h3F800000, 32'h7FC00000);
    issue("addf_inf_ninf", 5'b01111, 32'h7F800000, 32'hFF800000, 32'h7FC00000);
    issue("addf_inf_fin", 5'b01111, 32'hBF800000, 32'hFF800000, 32'hFF800000);
    issue("addf_ovf", 5'b01111, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1);
    issue("addf_denin", 5'b01111, 32'h00000001, 32'h3F800000, 32'h3F800000);
    issue("addf_tie_even", 5'b01111, 32'h3F800000, 32'h33800000, 32'h3F800000);
    issue("addf_tie_up", 5'b01111, 32'h3F800001, 32'h33800000, 32'h3F800002);
    issue("addf_mixed", 5'b01111, 32'h3FC00000, 32'hBF000000, 32'h3F800000);
    issue("addf_denout", 5'b01111, 32'h00C00000, 32'h80800000, 32'h0);

    issue("cvt_0", 5'b11110, 32'd0, 32'd7, 32'h0);
    issue("cvt_15", 5'b11110, 32'd15, 32'd0, 32'h41700000);
    issue("cvt_min", 5'b11110, 32'h80000000, 32'd0, 32'hCF000000);
    issue("cvt_m1", 5'b11110, 32'hFFFFFFFF, 32'd0, 32'hBF800000);
    issue("cvt_tie_even", 5'b11110, 32'd16777217, 32'd0, 32'h4B800000);
    issue("cvt_tie_up", 5'b11110, 32'd16777219, 32'd0, 32'h4B800002);
    issue("cvt_max", 5'b11110, 32'h7FFFFFFF, 32'd0, 32'h4F000000);

    for (int i = 0; i < 40; i++)
      issue($sformatf("rand%0d", i), iops[$urandom_range(0, 11)], $urandom, $urandom);

    issue("pre_reset", 5'b00010, 32'd5, 32'd6);
    issue("inflight", 5'b00001, 32'hF0F0F0F0, 32'h0F0F0F0F);
    #2 reset = 1'b1;
    q.delete();
    #1 chk("reset_async", {Result, Carryout, Overflow, Zero, Set}, 36'd0);
    @(negedge clk);
    chk("reset_hold", {Result, Carryout, Overflow, Zero, Set}, 36'd0);
    reset = 1'b0;
    issue("and_post", 5'b00000, 32'd7, 32'd5);
    issue("or_post", 5'b00001, 32'd1, 32'd4);
    issue("xor_post", 5'b00100, 32'd13, 32'd7);

    repeat (3) @(negedge clk);
    chk("drain", 36'(q.size()), 36'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
